collision_event_engine: RTL and testbench

Parametrised successor to the single-shot game controller. Resolves per-pixel overlaps between NUM_SHOTS shots, NUM_TARGETS scoring targets, the player, one hazard layer and one bonus object. Debounces each overlap to one event per frame and buffers score events in a FIFO drained by the score unit through a valid/ready handshake. Also manages player-hit cooldown and bonus re-arming. Sits between the object drawers and the score, life and timer units.

---
 rtl/game_event_pkg.sv | 18 +
 rtl/event_fifo.sv | 57 +++++
 rtl/collision_event_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_collision_event_engine.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_event_pkg.sv
// Shared types and BCD constants for the collision event engine and its score FIFO.
package game_event_pkg;

    localparam int EVT_W = 24;

    typedef struct packed {
        logic             sub;
        logic [EVT_W-1:0] delta;
    } score_evt_t;

    localparam logic [EVT_W-1:0] BCD_TARGET_DEFAULT = 24'h000040;
    localparam logic [EVT_W-1:0] BCD_BONUS_DEFAULT  = 24'h000100;
    localparam logic [EVT_W-1:0] BCD_PENALTY        = 24'h000050;

    typedef enum logic {READY, COOLDOWN} life_st_t;
    typedef enum logic {ARMED, DISARMED} bonus_st_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of score events; head is read straight from the storage registers.
module event_fifo
    import game_event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  score_evt_t i_din,
    input  logic       i_pop,
    output score_evt_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    score_evt_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/collision_event_engine.sv
// Resolves shot/target/player overlaps into debounced score, life and time events.
// Optional build macro COLLISION_PENALTY_EN adds a subtracting penalty event per life lost.
module collision_event_engine
    import game_event_pkg::*;
#(
    parameter int                               NUM_SHOTS    = 3,
    parameter int                               NUM_TARGETS  = 4,
    parameter int                               SCORE_W      = 24,
    parameter logic [NUM_TARGETS*SCORE_W-1:0]   TARGET_SCORE = {NUM_TARGETS{BCD_TARGET_DEFAULT}},
    parameter logic [SCORE_W-1:0]               BONUS_SCORE  = BCD_BONUS_DEFAULT,
    parameter int                               BONUS_TIME   = 60,
    parameter int                               HIT_COOLDOWN = 200,
    parameter int                               FIFO_DEPTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start_of_frame,
    input  logic                   i_rearm_tick,
    input  logic                   i_ghost_mode,
    input  logic                   i_dr_player,
    input  logic                   i_dr_hazard,
    input  logic                   i_dr_bonus,
    input  logic [NUM_SHOTS-1:0]   i_dr_shot,
    input  logic [NUM_TARGETS-1:0] i_dr_target,
    output logic [NUM_SHOTS-1:0]   o_shot_hit,
    output logic [NUM_TARGETS-1:0] o_target_hit,
    output logic                   o_score_valid,
    input  logic                   i_score_ready,
    output logic [SCORE_W-1:0]     o_score_delta,
    output logic                   o_score_sub,
    output logic                   o_life_dec,
    output logic                   o_time_req,
    output logic [10:0]            o_time_len,
    output logic [7:0]             o_drop_cnt
);

    localparam int CD_W = $clog2(HIT_COOLDOWN + 1);

    logic [NUM_SHOTS-1:0]   r_shot_hit;
    logic [NUM_TARGETS-1:0] r_target_hit;
    logic [NUM_TARGETS-1:0] r_latch;
    logic [NUM_TARGETS-1:0] r_pending;
    logic                   r_bonus_pend;
    logic                   r_life_dec;
    logic                   r_time_req;
    logic [10:0]            r_time_len;
    logic [7:0]             r_drop_cnt;
    logic [CD_W-1:0]        r_cd;
    life_st_t               r_life_st;
    bonus_st_t              r_bonus_st;

    logic                   w_any_shot;
    logic                   w_any_target;
    logic [NUM_TARGETS-1:0] w_hit;
    logic [NUM_TARGETS-1:0] w_first;
    logic [NUM_TARGETS-1:0] w_set_pend;
    logic [NUM_TARGETS-1:0] w_drop_tgt;
    logic [NUM_TARGETS-1:0] w_clr_tgt;
    logic                   w_clr_bonus;
    logic                   w_bonus_fire;
    logic                   w_bonus_drop;
    logic                   w_life_fire;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_can_push;
    logic                   w_full;
    logic                   w_empty;
    logic [7:0]             w_drop_num;
    logic [8:0]             w_drop_sum;
    logic [CD_W-1:0]        w_cd_next;
    life_st_t               w_life_st_next;
    bonus_st_t              w_bonus_st_next;
    score_evt_t             w_push_evt;
    score_evt_t             w_head;

    assign w_any_shot   = |i_dr_shot;
    assign w_any_target = |i_dr_target;

    // start_of_frame masks new hits so the latch clear always wins.
    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_target
        assign w_hit[gi]      = i_dr_target[gi] & w_any_shot;
        assign w_first[gi]    = w_hit[gi] & ~r_latch[gi] & ~i_start_of_frame;
        assign w_drop_tgt[gi] = w_first[gi] & r_pending[gi];
        assign w_set_pend[gi] = w_first[gi] & ~r_pending[gi];
    end

    // Bonus state machine
    always_comb begin
        w_bonus_st_next = r_bonus_st;
        w_bonus_fire    = 1'b0;
        case (r_bonus_st)
            ARMED: begin
                if (i_dr_player && i_dr_bonus) begin
                    w_bonus_fire = 1'b1;
                    if (!i_rearm_tick) begin
                        w_bonus_st_next = DISARMED;
                    end
                end
            end
            DISARMED: begin
                if (i_rearm_tick) begin
                    w_bonus_st_next = ARMED;
                end
            end
            default: w_bonus_st_next = ARMED;
        endcase
    end

    assign w_bonus_drop = w_bonus_fire & r_bonus_pend;

    // Life state machine; the cooldown counts frames, not cycles.
    always_comb begin
        w_life_st_next = r_life_st;
        w_cd_next      = r_cd;
        w_life_fire    = 1'b0;
        case (r_life_st)
            READY: begin
                if (i_dr_player && i_dr_hazard && !i_ghost_mode) begin
                    w_life_fire    = 1'b1;
                    w_life_st_next = COOLDOWN;
                    w_cd_next      = CD_W'(HIT_COOLDOWN);
                end
            end
            COOLDOWN: begin
                if (i_start_of_frame) begin
                    if (r_cd <= CD_W'(1)) begin
                        w_cd_next      = '0;
                        w_life_st_next = READY;
                    end else begin
                        w_cd_next = r_cd - 1'b1;
                    end
                end
            end
            default: w_life_st_next = READY;
        endcase
    end

`ifdef COLLISION_PENALTY_EN
    logic r_pen_pend;
    logic w_pen_drop;
    logic w_clr_pen;

    assign w_pen_drop  = w_life_fire & r_pen_pend;
    assign o_score_sub = w_head.sub;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pen_pend <= 1'b0;
        end else begin
            r_pen_pend <= (r_pen_pend & ~w_clr_pen) | (w_life_fire & ~r_pen_pend);
        end
    end
`else
    logic w_unused_sub;

    assign w_unused_sub = w_head.sub;
    assign o_score_sub  = 1'b0;
`endif

    assign w_pop      = o_score_valid && i_score_ready;
    assign w_can_push = !w_full || w_pop;

    // Pusher: bonus first, then lowest-index target, penalty last.
    always_comb begin
        w_push      = 1'b0;
        w_push_evt  = '0;
        w_clr_tgt   = '0;
        w_clr_bonus = 1'b0;
`ifdef COLLISION_PENALTY_EN
        w_clr_pen   = 1'b0;
`endif
        if (w_can_push) begin
            if (r_bonus_pend) begin
                w_push           = 1'b1;
                w_clr_bonus      = 1'b1;
                w_push_evt.delta = BONUS_SCORE;
            end else begin
                for (int t = NUM_TARGETS - 1; t >= 0; t--) begin
                    if (r_pending[t]) begin
                        w_push           = 1'b1;
                        w_clr_tgt        = '0;
                        w_clr_tgt[t]     = 1'b1;
                        w_push_evt.delta = TARGET_SCORE[t*SCORE_W +: SCORE_W];
                    end
                end
`ifdef COLLISION_PENALTY_EN
                if (!w_push && r_pen_pend) begin
                    w_push           = 1'b1;
                    w_clr_pen        = 1'b1;
                    w_push_evt.sub   = 1'b1;
                    w_push_evt.delta = BCD_PENALTY;
                end
`endif
            end
        end
    end

    always_comb begin
        w_drop_num = '0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            w_drop_num = w_drop_num + {7'd0, w_drop_tgt[t]};
        end
        w_drop_num = w_drop_num + {7'd0, w_bonus_drop};
`ifdef COLLISION_PENALTY_EN
        w_drop_num = w_drop_num + {7'd0, w_pen_drop};
`endif
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, w_drop_num};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shot_hit   <= '0;
            r_target_hit <= '0;
            r_latch      <= '0;
            r_pending    <= '0;
            r_bonus_pend <= 1'b0;
            r_life_dec   <= 1'b0;
            r_time_req   <= 1'b0;
            r_time_len   <= '0;
            r_drop_cnt   <= '0;
            r_cd         <= '0;
            r_life_st    <= READY;
            r_bonus_st   <= ARMED;
        end else begin
            r_shot_hit   <= i_dr_shot & {NUM_SHOTS{w_any_target}};
            r_target_hit <= w_first;
            r_latch      <= i_start_of_frame ? '0 : (r_latch | w_hit);
            r_pending    <= (r_pending & ~w_clr_tgt) | w_set_pend;
            r_bonus_pend <= (r_bonus_pend & ~w_clr_bonus) | (w_bonus_fire & ~r_bonus_pend);
            r_life_dec   <= w_life_fire;
            r_time_req   <= w_bonus_fire;
            r_time_len   <= w_bonus_fire ? 11'(BONUS_TIME) : 11'd0;
            r_drop_cnt   <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            r_cd         <= w_cd_next;
            r_life_st    <= w_life_st_next;
            r_bonus_st   <= w_bonus_st_next;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_din   (w_push_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_shot_hit    = r_shot_hit;
    assign o_target_hit  = r_target_hit;
    assign o_score_valid = !w_empty;
    assign o_score_delta = w_head.delta;
    assign o_life_dec    = r_life_dec;
    assign o_time_req    = r_time_req;
    assign o_time_len    = r_time_len;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_collision_event_engine.sv
// Directed bench for collision_event_engine: debounce, priority, back-pressure, life and bonus.
module tb_collision_event_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0, rearm = 1'b0, ghost = 1'b0;
    logic        player = 1'b0, hazard = 1'b0, bonus = 1'b0;
    logic [2:0]  shot = '0;
    logic [3:0]  target = '0;
    logic        ready = 1'b0;
    logic [2:0]  shot_hit;
    logic [3:0]  target_hit;
    logic        valid, sub, life_dec, time_req;
    logic [23:0] delta;
    logic [10:0] time_len;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, written only by the monitor process
    int          th_cnt [4];
    int          sh_cnt [3];
    int          life_cnt = 0;
    int          treq_cnt = 0;
    logic [10:0] last_tlen = '0;
    logic [24:0] pop_log [256];
    int          pop_n = 0;

    always #5 clk = ~clk;

    collision_event_engine #(
        .TARGET_SCORE ({24'h000080, 24'h000060, 24'h000055, 24'h000040})
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_start_of_frame (sof),
        .i_rearm_tick     (rearm),
        .i_ghost_mode     (ghost),
        .i_dr_player      (player),
        .i_dr_hazard      (hazard),
        .i_dr_bonus       (bonus),
        .i_dr_shot        (shot),
        .i_dr_target      (target),
        .o_shot_hit       (shot_hit),
        .o_target_hit     (target_hit),
        .o_score_valid    (valid),
        .i_score_ready    (ready),
        .o_score_delta    (delta),
        .o_score_sub      (sub),
        .o_life_dec       (life_dec),
        .o_time_req       (time_req),
        .o_time_len       (time_len),
        .o_drop_cnt       (drop_cnt)
    );

    always @(posedge clk) begin
        for (int t = 0; t < 4; t++) if (target_hit[t]) th_cnt[t] = th_cnt[t] + 1;
        for (int s = 0; s < 3; s++) if (shot_hit[s]) sh_cnt[s] = sh_cnt[s] + 1;
        if (life_dec) life_cnt = life_cnt + 1;
        if (time_req) begin
            treq_cnt  = treq_cnt + 1;
            last_tlen = time_len;
        end
        if (valid && ready && pop_n < 256) begin
            pop_log[pop_n] = {sub, delta};
            $display("pop %0d: sub=%0b delta=%06h", pop_n, sub, delta);
            pop_n = pop_n + 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int n = 1);
        repeat (n) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            tick();
        end
    endtask

    task automatic idle_inputs();
        shot = '0; target = '0; player = 1'b0; hazard = 1'b0; bonus = 1'b0;
        rearm = 1'b0; ghost = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_checks++; if (delta !== 24'h0) begin n_fail++; $display("FAIL reset_delta: got %06h want 000000", delta); end
        n_checks++; if (sub !== 1'b0) begin n_fail++; $display("FAIL reset_sub: got %0b want 0", sub); end
        n_checks++; if ({shot_hit, target_hit, life_dec, time_req} !== 9'd0) begin n_fail++; $display("FAIL reset_pulses: got %03h want 000", {shot_hit, target_hit, life_dec, time_req}); end
        n_checks++; if (time_len !== 11'd0) begin n_fail++; $display("FAIL reset_time_len: got %0d want 0", time_len); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_hit();
        int b0, s1, p0;
        b0 = th_cnt[0]; s1 = sh_cnt[1]; p0 = pop_n;
        ready = 1'b0;
        frame();
        shot = 3'b010; target = 4'b0001;
        tick(5);
        idle_inputs();
        tick(2);
        n_checks++; if (th_cnt[0] - b0 !== 1) begin n_fail++; $display("FAIL single_target_hit: got %0d pulses want 1", th_cnt[0] - b0); end
        n_checks++; if (sh_cnt[1] - s1 !== 5) begin n_fail++; $display("FAIL single_shot_hit: got %0d pulses want 5", sh_cnt[1] - s1); end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", valid); end
        n_checks++; if (delta !== 24'h000040) begin n_fail++; $display("FAIL single_delta: got %06h want 000040", delta); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL single_drop: got %0d want 0", drop_cnt); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_checks++; if (pop_n - p0 !== 1) begin n_fail++; $display("FAIL single_pops: got %0d want 1", pop_n - p0); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %0b want 0", valid); end
    endtask

    task automatic test_multi_frame();
        int b0, p0;
        b0 = th_cnt[0]; p0 = pop_n;
        ready = 1'b1;
        repeat (3) begin
            frame();
            shot = 3'b010; target = 4'b0001;
            tick(3);
            idle_inputs();
            tick(2);
        end
        tick(2);
        ready = 1'b0;
        n_checks++; if (th_cnt[0] - b0 !== 3) begin n_fail++; $display("FAIL multi_target_hit: got %0d want 3", th_cnt[0] - b0); end
        n_checks++; if (pop_n - p0 !== 3) begin n_fail++; $display("FAIL multi_pops: got %0d want 3", pop_n - p0); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (pop_log[p0+i] !== {1'b0, 24'h000040}) begin
                n_fail++; $display("FAIL multi_evt%0d: got %07h want 0000040", i, pop_log[p0+i]);
            end
        end
    endtask

    task automatic test_priority();
        int p0;
        p0 = pop_n;
        ready = 1'b0;
        frame();
        shot = 3'b001; target = 4'b0101;
        tick();
        idle_inputs();
        tick(3);
        n_checks++; if (delta !== 24'h000040) begin n_fail++; $display("FAIL prio_head: got %06h want 000040", delta); end
        tick(3);
        n_checks++; if (valid !== 1'b1 || delta !== 24'h000040) begin n_fail++; $display("FAIL prio_stable: got v=%0b %06h want v=1 000040", valid, delta); end
        ready = 1'b1; tick(); ready = 1'b0;
        n_checks++; if (delta !== 24'h000060) begin n_fail++; $display("FAIL prio_second: got %06h want 000060", delta); end
        ready = 1'b1; tick(); ready = 1'b0;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL prio_empty: got %0b want 0", valid); end
        n_checks++; if (pop_n - p0 !== 2) begin n_fail++; $display("FAIL prio_pops: got %0d want 2", pop_n - p0); end
    endtask

    task automatic test_backpressure();
        int          seq [7] = '{0, 1, 2, 3, 0, 1, 0};
        logic [23:0] exp [6] = '{24'h40, 24'h55, 24'h60, 24'h80, 24'h40, 24'h55};
        int          p0;
        p0 = pop_n;
        ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            frame();
            shot = 3'b100;
            target = 4'(1 << seq[i]);
            tick();
            idle_inputs();
            tick(2);
        end
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_drop: got %0d want 1", drop_cnt); end
        n_checks++; if (valid !== 1'b1 || delta !== 24'h000040) begin n_fail++; $display("FAIL bp_head: got v=%0b %06h want v=1 000040", valid, delta); end
        ready = 1'b1;
        for (int i = 0; i < 30 && valid; i++) tick();
        ready = 1'b0;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_timeout: got valid=%0b want 0", valid); end
        n_checks++; if (pop_n - p0 !== 6) begin n_fail++; $display("FAIL bp_pops: got %0d want 6", pop_n - p0); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (pop_log[p0+i] !== {1'b0, exp[i]}) begin
                n_fail++; $display("FAIL bp_order%0d: got %07h want %07h", i, pop_log[p0+i], {1'b0, exp[i]});
            end
        end
    endtask

    task automatic test_sof_collision();
        int b0, p0;
        b0 = th_cnt[0]; p0 = pop_n;
        ready = 1'b1;
        sof = 1'b1; shot = 3'b010; target = 4'b0001;
        tick();
        sof = 1'b0; idle_inputs();
        tick(3);
        n_checks++; if (th_cnt[0] - b0 !== 0) begin n_fail++; $display("FAIL sofcol_hit: got %0d want 0", th_cnt[0] - b0); end
        n_checks++; if (pop_n - p0 !== 0) begin n_fail++; $display("FAIL sofcol_pops: got %0d want 0", pop_n - p0); end
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL sofcol_drop: got %0d want 1", drop_cnt); end
        shot = 3'b010; target = 4'b0001;
        tick();
        idle_inputs();
        tick(3);
        n_checks++; if (th_cnt[0] - b0 !== 1) begin n_fail++; $display("FAIL sofcol_after: got %0d want 1", th_cnt[0] - b0); end
        ready = 1'b0;
    endtask

    task automatic test_life();
        int b0;
        b0 = life_cnt;
        player = 1'b1; hazard = 1'b1;
        tick(3);
        idle_inputs(); tick();
        n_checks++; if (life_cnt - b0 !== 1) begin n_fail++; $display("FAIL life_first: got %0d want 1", life_cnt - b0); end
        frame(10);
        player = 1'b1; hazard = 1'b1; tick(); idle_inputs(); tick();
        n_checks++; if (life_cnt - b0 !== 1) begin n_fail++; $display("FAIL life_cooldown10: got %0d want 1", life_cnt - b0); end
        frame(189);
        player = 1'b1; hazard = 1'b1; tick(); idle_inputs(); tick();
        n_checks++; if (life_cnt - b0 !== 1) begin n_fail++; $display("FAIL life_cooldown199: got %0d want 1", life_cnt - b0); end
        frame(1);
        player = 1'b1; hazard = 1'b1; tick(); idle_inputs(); tick();
        n_checks++; if (life_cnt - b0 !== 2) begin n_fail++; $display("FAIL life_rehit: got %0d want 2", life_cnt - b0); end
        ghost = 1'b1;
        frame(200);
        player = 1'b1; hazard = 1'b1; tick(); player = 1'b0; hazard = 1'b0; tick();
        n_checks++; if (life_cnt - b0 !== 2) begin n_fail++; $display("FAIL life_ghost: got %0d want 2", life_cnt - b0); end
        idle_inputs();
        player = 1'b1; hazard = 1'b1; tick(); idle_inputs(); tick();
        n_checks++; if (life_cnt - b0 !== 3) begin n_fail++; $display("FAIL life_after_ghost: got %0d want 3", life_cnt - b0); end
    endtask

    task automatic test_bonus();
        int b0, p0;
        b0 = treq_cnt; p0 = pop_n;
        ready = 1'b1;
        player = 1'b1; bonus = 1'b1; tick(); idle_inputs(); tick(3);
        n_checks++; if (treq_cnt - b0 !== 1) begin n_fail++; $display("FAIL bonus_treq: got %0d want 1", treq_cnt - b0); end
        n_checks++; if (last_tlen !== 11'd60) begin n_fail++; $display("FAIL bonus_tlen: got %0d want 60", last_tlen); end
        n_checks++; if (time_len !== 11'd0) begin n_fail++; $display("FAIL bonus_tlen_idle: got %0d want 0", time_len); end
        n_checks++; if (pop_n - p0 !== 1 || pop_log[p0] !== {1'b0, 24'h000100}) begin n_fail++; $display("FAIL bonus_evt: got n=%0d %07h want n=1 0000100", pop_n - p0, pop_log[p0]); end
        player = 1'b1; bonus = 1'b1; tick(3); idle_inputs(); tick(2);
        n_checks++; if (treq_cnt - b0 !== 1 || pop_n - p0 !== 1) begin n_fail++; $display("FAIL bonus_disarmed: got treq=%0d pops=%0d want 1 1", treq_cnt - b0, pop_n - p0); end
        rearm = 1'b1; tick(); rearm = 1'b0;
        player = 1'b1; bonus = 1'b1; tick(); idle_inputs(); tick(3);
        n_checks++; if (treq_cnt - b0 !== 2 || pop_n - p0 !== 2) begin n_fail++; $display("FAIL bonus_rearm: got treq=%0d pops=%0d want 2 2", treq_cnt - b0, pop_n - p0); end
        rearm = 1'b1; tick(); rearm = 1'b0; tick();
        rearm = 1'b1; player = 1'b1; bonus = 1'b1; tick(); idle_inputs(); tick(2);
        player = 1'b1; bonus = 1'b1; tick(); idle_inputs(); tick(3);
        n_checks++; if (treq_cnt - b0 !== 4 || pop_n - p0 !== 4) begin n_fail++; $display("FAIL bonus_coincide: got treq=%0d pops=%0d want 4 4", treq_cnt - b0, pop_n - p0); end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        frame();
        shot = 3'b001; target = 4'b1000; tick(); idle_inputs(); tick(2);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %0b want 1", valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0 || delta !== 24'h0) begin n_fail++; $display("FAIL rmid_async: got v=%0b %06h want v=0 000000", valid, delta); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt); end
        tick();
        rst = 1'b0;
        tick(3);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_post: got %0b want 0", valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) th_cnt[i] = 0;
        for (int i = 0; i < 3; i++) sh_cnt[i] = 0;
        test_reset();
        test_single_hit();
        test_multi_frame();
        test_priority();
        test_backpressure();
        test_sof_collision();
        test_life();
        test_bonus();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
